// File: rtl/csa_acc_pkg.sv
// Shared types and helpers for the carry-save streaming accumulator.
// Holds the controller state encoding, default sizing and the 3:2 compressor cell.
package csa_acc_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int ACC_WIDTH_DEF = WIDTH_DEF + 8;
  localparam int CHUNK_DEF     = 8;
  localparam int NCHUNK_DEF    = ACC_WIDTH_DEF / CHUNK_DEF;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Chunk-index width; never collapses to zero bits for a single-chunk build.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int CHUNK_IDX_W = idx_width(NCHUNK_DEF);

  // One full-adder cell: returns {sum, carry} of three equally weighted bits.
  function automatic logic [1:0] csa3(input logic x, input logic y, input logic z);
    return {x ^ y ^ z, (x & y) | (x & z) | (y & z)};
  endfunction

endpackage

// File: rtl/csa_stage.sv
// Combinational W-bit three-input carry-save compressor.
// The carry vector is already shifted to its true weight and truncated to W bits.
module csa_stage
  import csa_acc_pkg::*;
#(
  parameter int W = ACC_WIDTH_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [1:0] cell_s;

  // Per-bit compression; the majority of bit i lands at bit i+1, the top majority wraps away.
  always_comb begin
    sum    = '0;
    carry  = '0;
    cell_s = 2'b00;
    for (int i = 1; i < W; i++) begin
      cell_s   = csa3(x[i-1], y[i-1], z[i-1]);
      carry[i] = cell_s[0];
    end
    for (int i = 0; i < W; i++) begin
      cell_s = csa3(x[i], y[i], z[i]);
      sum[i] = cell_s[1];
    end
  end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming packet accumulator: operands fold into a carry-save pair each cycle,
// then a CHUNK-bit-per-cycle ripple resolver produces the binary total.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_WIDTH = WIDTH + 8,
  parameter int CHUNK     = CHUNK_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);

  localparam int NCHUNK = ACC_WIDTH / CHUNK;
  localparam int KW     = idx_width(NCHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  state_t               state_r;
  logic [ACC_WIDTH-1:0] s_r;
  logic [ACC_WIDTH-1:0] c_r;
  logic [ACC_WIDTH-1:0] r_r;
  logic [KW-1:0]        k_r;
  logic                 cy_r;

  logic [ACC_WIDTH-1:0] d_s;
  logic [ACC_WIDTH-1:0] s_nxt_s;
  logic [ACC_WIDTH-1:0] c_nxt_s;
  logic [CHUNK-1:0]     s_chunk_s;
  logic [CHUNK-1:0]     c_chunk_s;
  logic [CHUNK:0]       chunk_sum_s;

  assign d_s = ACC_WIDTH'(in_data);

  csa_stage #(
    .W(ACC_WIDTH)
  ) u_csa_stage (
    .x     (s_r),
    .y     (c_r),
    .z     (d_s),
    .sum   (s_nxt_s),
    .carry (c_nxt_s)
  );

  // Resolver slice: one CHUNK-wide add of the selected sum/carry chunks plus the running carry.
  always_comb begin
    s_chunk_s   = s_r[k_r*CHUNK +: CHUNK];
    c_chunk_s   = c_r[k_r*CHUNK +: CHUNK];
    chunk_sum_s = {1'b0, s_chunk_s} + {1'b0, c_chunk_s} + {{CHUNK{1'b0}}, cy_r};
  end

  // Controller and datapath registers; the final resolver carry-out is dropped so the sum wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
      s_r     <= '0;
      c_r     <= '0;
      r_r     <= '0;
      k_r     <= '0;
      cy_r    <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_valid) begin
            s_r <= s_nxt_s;
            c_r <= c_nxt_s;
            if (in_last) begin
              state_r <= RESOLVE;
              k_r     <= '0;
              cy_r    <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_r[k_r*CHUNK +: CHUNK] <= chunk_sum_s[CHUNK-1:0];
          cy_r                    <= chunk_sum_s[CHUNK];
          if (k_r == K_LAST) begin
            state_r <= OUTPUT;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            s_r     <= '0;
            c_r     <= '0;
            state_r <= ACCUM;
          end
        end
        default: begin
          state_r <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == OUTPUT);
  assign out_data  = r_r;

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator in the 8/16/4 configuration: a negedge monitor
// sums accepted operands into expected packet totals and compares them at each out handshake.
module tb_csa_accumulator;

  localparam int W  = 8;
  localparam int AW = 16;
  localparam int CH = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_last   = 1'b0;
  logic [W-1:0]  in_data   = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_data;

  int            errors = 0;
  int            checks = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] model_acc = '0;
  int            out_hs = 0;
  int            cyc = 0;
  bit            rand_ready = 1'b0;
  bit            ready_force = 1'b1;

  csa_accumulator #(
    .WIDTH     (W),
    .ACC_WIDTH (AW),
    .CHUNK     (CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(1, 0) == 1) : ready_force;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push a total when a last beat is accepted, pop it at the out handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_acc = '0;
    end else begin
      if (in_valid && in_ready) begin
        model_acc = model_acc + AW'(in_data);
        if (in_last) begin
          exp_q.push_back(model_acc);
          model_acc = '0;
        end
      end
      if (out_valid && out_ready) begin
        out_hs++;
        check_eq("out_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check_eq("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input bit last, input int gap_pct);
    int guard;
    while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("in_accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts edges from the last-beat handshake edge until out_valid is seen; ends at a negedge.
  task automatic wait_out_valid(output int edges);
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      @(negedge clk);
    end
    if (!out_valid) check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !in_ready) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check_eq("idle_reached", 32'(g < 300), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int c0;
    int hs0;
    int g;
    int len;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 3 + 5 + 7 with latency measured from the last handshake
    send_beat(8'd3, 1'b0, 0);
    send_beat(8'd5, 1'b0, 0);
    send_beat(8'd7, 1'b1, 0);
    wait_out_valid(n);
    check_eq("latency", 32'(n), 32'd5);
    check_eq("sum_3_5_7", 32'(out_data), 32'h000F);
    @(posedge clk);
    #1;
    wait_idle();

    // full carry ripple across all chunks, then wrap
    c0 = cyc;
    for (int i = 0; i < 257; i++) send_beat(8'hFF, (i == 256), 0);
    check_eq("throughput_257", 32'(cyc - c0), 32'd257);
    wait_out_valid(n);
    check_eq("sum_257_ff", 32'(out_data), 32'hFFFF);
    @(posedge clk);
    #1;
    wait_idle();
    for (int i = 0; i < 258; i++) send_beat(8'hFF, (i == 257), 0);
    wait_out_valid(n);
    check_eq("sum_258_ff", 32'(out_data), 32'h00FE);
    @(posedge clk);
    #1;
    wait_idle();

    // single-beat packets; the second proves S/C were cleared
    send_beat(8'hAB, 1'b1, 0);
    wait_out_valid(n);
    check_eq("single_ab", 32'(out_data), 32'h00AB);
    @(posedge clk);
    #1;
    wait_idle();
    send_beat(8'h01, 1'b1, 0);
    wait_out_valid(n);
    check_eq("single_01", 32'(out_data), 32'h0001);
    @(posedge clk);
    #1;
    wait_idle();

    // backpressure: output held 10 cycles while a new operand waits upstream
    ready_force = 1'b0;
    hs0 = out_hs;
    send_beat(8'd1, 1'b0, 0);
    send_beat(8'd2, 1'b1, 0);
    wait_out_valid(n);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_out_data", 32'(out_data), 32'h0003);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    ready_force = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check_eq("stall_release", 32'(in_ready), 32'd1);
    check_eq("stall_one_handshake", 32'(out_hs - hs0), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();

    // reset in the second resolve cycle discards the packet
    send_beat(8'h10, 1'b0, 0);
    send_beat(8'h20, 1'b1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(8'd1, 1'b0, 0);
    send_beat(8'd2, 1'b1, 0);
    wait_out_valid(n);
    check_eq("post_rst_sum", 32'(out_data), 32'h0003);
    @(posedge clk);
    #1;
    wait_idle();

    // random valid gaps and random out_ready over 1000 packets
    rand_ready = 1'b1;
    hs0 = out_hs;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(6, 1);
      for (int b = 0; b < len; b++) begin
        send_beat(W'($urandom_range(255, 0)), (b == len - 1), 30);
      end
    end
    rand_ready = 1'b0;
    wait_idle();
    check_eq("random_packets", 32'(out_hs - hs0), 32'd1000);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Streaming multi-operand accumulator built around the team's carry-save datapath. Operands arrive on a valid/ready stream and are compressed each cycle into a redundant sum/carry pair, so no carry-propagate adder sits on the per-operand path. When a packet's last operand is accepted, a chunked carry-propagate resolver converts the pair to binary over several cycles and presents the total on a valid/ready output stream. It is the sequential consumer of carry-save form, the counterpart to the single-cycle three-input carry-save adder.

## Interface
- WIDTH, 32: operand width in bits, unsigned.
- ACC_WIDTH, WIDTH+8: accumulator and result width. Sum wraps modulo 2^ACC_WIDTH.
- CHUNK, 8: bits resolved per cycle. ACC_WIDTH % CHUNK must be 0. NCHUNK = ACC_WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  accumulator accepts operand.
- in_data  in  WIDTH  operand, zero-extended to ACC_WIDTH.
- in_last  in  1  final operand of packet; qualified by handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_WIDTH  binary packet sum.

## Operation
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESOLVE: in_ready=0, out_valid=0.
  - OUTPUT: in_ready=0, out_valid=1.
- ACCUM, on in_valid&in_ready:
  - S' = S^C^D
  - C' = ({S&C | S&D | C&D} << 1) truncated to ACC_WIDTH
  - D is zero-extended in_data.
  - If in_last is also high: go to RESOLVE with chunk index k=0 and carry register cy=0.
- RESOLVE: each cycle computes {cy', R[k*CHUNK +: CHUNK]} = S[chunk k] + C[chunk k] + cy, then k++. After chunk NCHUNK-1 completes, go to OUTPUT. The final carry-out is discarded (wrap).
- OUTPUT:
  - out_data = R, held stable while out_valid=1 and out_ready=0.
  - On out_ready: clear S and C to 0 and return to ACCUM.
- in_valid is ignored outside ACCUM. The upstream must hold its data; no operand is dropped or duplicated.
- A single-beat packet (first beat carries in_last) yields out_data = that operand.
- An empty packet is impossible: a packet always contains at least one beat.
- Reset, including mid-RESOLVE or mid-OUTPUT:
  - State returns to ACCUM.
  - S, C, R, k, cy are cleared to 0.
  - in_ready=1 and out_valid=0 while rst_n is low and after release.
  - The partial packet is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0.
- The in_last handshake occurs at edge t.
- RESOLVE occupies cycles t+1 through t+NCHUNK.
- out_valid rises after edge t+NCHUNK, so it is visible in cycle t+NCHUNK+1.
- Minimum time between packets is NCHUNK+2 cycles: NCHUNK resolve cycles, one output cycle, and one return-to-ACCUM cycle. The next operand can be accepted the cycle after the out handshake.
- Throughput in ACCUM is one operand per cycle. The per-operand critical path is one full-adder level.
- All outputs are registered or decoded from the state register only. No input-to-output combinational path exists.

## Structure
- Package csa_acc_pkg holds:
  - state enum {ACCUM, RESOLVE, OUTPUT}
  - chunk-index width constant, $clog2(NCHUNK)
  - function csa3(x, y, z) returning {sum, carry}
- Sub-module csa_stage: combinational, ACC_WIDTH-wide three-input compressor. It is instantiated once in the ACCUM datapath.
- The resolver adder is inline. The CHUNK-bit slice is selected by k, and R is written per chunk.

## Test plan
Configuration for all scenarios: WIDTH=8, ACC_WIDTH=16, CHUNK=4, NCHUNK=4, out_ready=1 unless stated.
- Beats 3, 5, 7(last) -> out_data=0x000F, with out_valid first high exactly 5 cycles after the last handshake.
- 257 beats of 0xFF, the last flagged -> 0xFFFF. Next packet of 258 beats of 0xFF -> 0x00FE. This exercises the full chunk carry ripple and wrap.
- Single beat 0xAB with in_last -> 0x00AB. S and C are cleared afterwards.
- Packet 1, 2(last); hold out_ready=0 for 10 cycles -> out_data=0x0003 stable, in_ready=0 throughout, and exactly one out handshake.
- Assert rst_n low during the second RESOLVE cycle of a 0x10, 0x20 packet -> out_valid=0 and in_ready=1 immediately. The following packet 1, 2(last) -> 0x0003 with no residue.
- Random in_valid/out_ready toggling over 1000 packets versus a reference model -> all sums match modulo 2^16, with no operands lost.
